// File: rtl/clb_config_loader.sv
// Configuration frame loader: parses a handshaked byte stream into per-CLB
// 23-bit config words and strobes them onto the shared bits bus via one-hot wr_en.
module clb_config_loader #(
  parameter int NUM_CLB = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [22:0]        bits,
  output logic [NUM_CLB-1:0] wr_en,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2:0]         err_code
);

  localparam logic [7:0] HDR_BYTE  = 8'hA5;
  localparam logic [8:0] NUM_CLB_W = 9'(NUM_CLB);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_CNT, S_ADDR, S_D0, S_D1, S_D2, S_WRITE, S_CSUM, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, csum_q, csum_d;
  logic [7:0]  n_q, n_d, addr_q, addr_d, d0_q, d0_d, d1_q, d1_d;
  logic [22:0] bits_q, bits_d;
  logic        done_q, done_d, err_q, err_d;
  logic [2:0]  code_q, code_d;
  logic        accept;

  assign s_ready  = state_q inside {S_HDR, S_CNT, S_ADDR, S_D0, S_D1, S_D2, S_CSUM};
  assign accept   = s_valid && s_ready;
  assign busy     = (state_q != S_IDLE);
  assign bits     = bits_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      csum_q  <= '0;
      bits_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      bits_q  <= bits_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // Record payload holding registers are always written before being read.
  always_ff @(posedge clk) begin
    n_q    <= n_d;
    addr_q <= addr_d;
    d0_q   <= d0_d;
    d1_q   <= d1_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    bits_d  = bits_q;
    done_d  = 1'b0;
    err_d   = err_q;
    code_d  = code_q;
    n_d     = n_q;
    addr_d  = addr_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_HDR;
        err_d   = 1'b0;
        code_d  = '0;
        csum_d  = '0;
        cnt_d   = '0;
      end
      S_HDR: if (accept) begin
        if (s_data != HDR_BYTE) begin
          state_d = S_ERR; err_d = 1'b1; code_d = 3'd1;
        end else begin
          state_d = S_CNT;
        end
      end
      S_CNT: if (accept) begin
        csum_d = csum_q ^ s_data;
        if (s_data == 8'd0 || {1'b0, s_data} > NUM_CLB_W) begin
          state_d = S_ERR; err_d = 1'b1; code_d = 3'd2;
        end else begin
          n_d     = s_data;
          state_d = S_ADDR;
        end
      end
      S_ADDR: if (accept) begin
        csum_d = csum_q ^ s_data;
        if ({1'b0, s_data} >= NUM_CLB_W) begin
          state_d = S_ERR; err_d = 1'b1; code_d = 3'd3;
        end else begin
          addr_d  = s_data;
          state_d = S_D0;
        end
      end
      S_D0: if (accept) begin
        csum_d  = csum_q ^ s_data;
        d0_d    = s_data;
        state_d = S_D1;
      end
      S_D1: if (accept) begin
        csum_d  = csum_q ^ s_data;
        d1_d    = s_data;
        state_d = S_D2;
      end
      S_D2: if (accept) begin
        csum_d = csum_q ^ s_data;
        if (s_data[7]) begin
          state_d = S_ERR; err_d = 1'b1; code_d = 3'd4;
        end else begin
          bits_d  = {s_data[6:0], d1_q, d0_q};
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        cnt_d   = cnt_q + 8'd1;
        state_d = (cnt_d == n_q) ? S_CSUM : S_ADDR;
      end
      S_CSUM: if (accept) begin
        if (s_data == csum_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_ERR; err_d = 1'b1; code_d = 3'd5;
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Write strobe is decoded from state so it can never outlive the WRITE cycle.
  always_comb begin
    wr_en = '0;
    if (state_q == S_WRITE) begin
      for (int i = 0; i < NUM_CLB; i++) begin
        if (addr_q == 8'(i)) wr_en[i] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clb_config_loader.sv
// Bench for clb_config_loader: a frame-level reference parser predicts every
// write and the final outcome; a per-cycle monitor checks the strobes against it.
module tb_clb_config_loader;

  localparam int NUM_CLB = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [7:0]         s_data = 8'h00;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [22:0]        bits;
  logic [NUM_CLB-1:0] wr_en;
  logic               busy, done, err;
  logic [2:0]         err_code;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [15:0] wr;
    logic [22:0] bits;
  } wr_t;

  wr_t         exp_q[$];
  int          exp_code;
  int          exp_len;
  logic [22:0] last_bits = '0;
  int          done_cnt = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  clb_config_loader #(.NUM_CLB(NUM_CLB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .bits(bits), .wr_en(wr_en), .busy(busy), .done(done),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
    end
  endtask

  // Reference parser: walks the byte list by the frame rules. Code 7 means the
  // list ended before the frame did.
  task automatic model(input byte_q_t f);
    logic [7:0] x, n, a;
    int b;
    wr_t e;
    exp_q.delete();
    exp_code = 7;
    exp_len  = f.size();
    if (f.size() < 1) return;
    if (f[0] != 8'hA5) begin exp_code = 1; exp_len = 1; return; end
    if (f.size() < 2) return;
    n = f[1];
    x = n;
    if (n == 8'd0 || int'(n) > NUM_CLB) begin exp_code = 2; exp_len = 2; return; end
    for (int r = 0; r < int'(n); r++) begin
      b = 2 + 4 * r;
      if (f.size() < b + 1) return;
      a = f[b];
      x ^= a;
      if (int'(a) >= NUM_CLB) begin exp_code = 3; exp_len = b + 1; return; end
      if (f.size() < b + 4) return;
      x = x ^ f[b+1] ^ f[b+2] ^ f[b+3];
      if (f[b+3][7]) begin exp_code = 4; exp_len = b + 4; return; end
      e.wr   = 16'h0001 << a;
      e.bits = {f[b+3][6:0], f[b+2], f[b+1]};
      exp_q.push_back(e);
      last_bits = e.bits;
    end
    b = 2 + 4 * int'(n);
    if (f.size() < b + 1) return;
    exp_code = (f[b] == x) ? 0 : 5;
    exp_len  = b + 1;
  endtask

  function automatic logic [7:0] xor_body(input byte_q_t f);
    logic [7:0] x = 8'h00;
    for (int i = 1; i < f.size(); i++) x ^= f[i];
    return x;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en != '0) begin
        wr_t e;
        chk("wr_onehot", 32'($onehot(wr_en)), 32'd1);
        chk("ready_in_write", 32'(s_ready), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_wr", 32'(wr_en), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_en", 32'(wr_en), 32'(e.wr));
          chk("bits", 32'(bits), 32'(e.bits));
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic run_frame(input byte_q_t f, input int pct, input int want_code, input string tag);
    int idx = 0;
    int guard = 0;
    model(f);
    chk({tag, "_model_code"}, exp_code, want_code);
    done_cnt = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({tag, "_start_busy"}, 32'(busy), 32'd1);
    chk({tag, "_start_ready"}, 32'(s_ready), 32'd1);
    chk({tag, "_start_errclr"}, {28'd0, err, err_code}, 32'd0);
    while (idx < exp_len) begin
      s_valid = ($urandom_range(99) < pct);
      s_data  = f[idx];
      start   = (pct < 100) && busy && ($urandom_range(3) == 0);
      if (s_valid && s_ready) idx++;
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        chk({tag, "_feed_timeout"}, 32'd1, 32'd0);
        break;
      end
    end
    s_valid = 1'b0;
    start   = 1'b0;
    if (want_code == 7) return;
    if (exp_code == 0) begin
      chk({tag, "_done_t1"}, 32'(done), 32'd1);
      chk({tag, "_busy_t1"}, 32'(busy), 32'd0);
    end else begin
      chk({tag, "_err_t1"}, 32'(err), 32'd1);
      chk({tag, "_busy_t1"}, 32'(busy), 32'd1);
      chk({tag, "_code_t1"}, 32'(err_code), 32'(exp_code));
    end
    @(negedge clk);
    chk({tag, "_done_t2"}, 32'(done), 32'd0);
    chk({tag, "_busy_t2"}, 32'(busy), 32'd0);
    chk({tag, "_ready_t2"}, 32'(s_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk({tag, "_writes_left"}, exp_q.size(), 32'd0);
    chk({tag, "_done_count"}, done_cnt, (exp_code == 0) ? 32'd1 : 32'd0);
    chk({tag, "_err_final"}, 32'(err), (exp_code == 0) ? 32'd0 : 32'd1);
    chk({tag, "_code_final"}, 32'(err_code), 32'(exp_code));
    chk({tag, "_bits_hold"}, 32'(bits), 32'(last_bits));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_bits"}, 32'(bits), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_code"}, 32'(err_code), 32'd0);
  endtask

  initial begin
    byte_q_t f1, f2, f4, ft;

    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    f1 = '{8'hA5, 8'h01, 8'h03, 8'h34, 8'h12, 8'h05, 8'h21};
    model(f1);
    chk("pin1_n", exp_q.size(), 32'd1);
    chk("pin1_wr", 32'(exp_q[0].wr), 32'h0008);
    chk("pin1_bits", 32'(exp_q[0].bits), 32'h051234);
    run_frame(f1, 100, 0, "single");

    f2 = '{8'hA5, 8'h02, 8'h00, 8'hFF, 8'hFF, 8'h7F, 8'h0F, 8'h01, 8'h00, 8'h00, 8'h73};
    model(f2);
    chk("pin2_n", exp_q.size(), 32'd2);
    chk("pin2_wr0", 32'(exp_q[0].wr), 32'h0001);
    chk("pin2_bits0", 32'(exp_q[0].bits), 32'h7FFFFF);
    chk("pin2_wr1", 32'(exp_q[1].wr), 32'h8000);
    chk("pin2_bits1", 32'(exp_q[1].bits), 32'h000001);
    run_frame(f2, 100, 0, "two_rec");

    run_frame('{8'h5A}, 100, 1, "bad_hdr");
    run_frame('{8'hA5, 8'h11}, 100, 2, "bad_cnt");
    run_frame('{8'hA5, 8'h01, 8'h10}, 100, 3, "bad_addr");
    run_frame('{8'hA5, 8'h01, 8'h03, 8'h34, 8'h12, 8'h80}, 100, 4, "resv_bit");

    ft = '{8'hA5, 8'h01, 8'h03, 8'h34, 8'h12, 8'h05, 8'h20};
    model(ft);
    chk("pin5_n", exp_q.size(), 32'd1);
    run_frame(ft, 100, 5, "bad_csum");

    f4 = '{8'hA5, 8'h04, 8'h05, 8'h11, 8'h22, 8'h33, 8'h09, 8'hAA, 8'hBB, 8'h4C,
           8'h05, 8'h01, 8'h02, 8'h03, 8'h0E, 8'hFF, 8'h00, 8'h7F};
    f4.push_back(xor_body(f4));
    run_frame(f4, 100, 0, "four_rec");
    run_frame(f4, 50, 0, "four_rec_bp");

    ft.delete();
    for (int i = 0; i < 9; i++) ft.push_back(f4[i]);
    run_frame(ft, 100, 7, "reset_mid");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_idle_outputs("async_rst");
    chk("rst_writes_left", exp_q.size(), 32'd0);
    last_bits = '0;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    run_frame(f1, 100, 0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
